// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
//
// Iterative DES key schedule. One 64-bit key is expanded into the sixteen
// 48-bit round keys, one round key per clock, and the full set is presented
// on a 768-bit registered bus for the downstream DES datapath. The output bus
// is double-buffered: round_keys only changes on the completion edge, so the
// consumer keeps the previous key set while a new one is being computed.
//
// Ports:
//   clk         in   1    rising-edge clock
//   rst_n       in   1    synchronous, active-low reset
//   start       in   1    request a new schedule (sampled only while ready=1)
//   key         in   64   DES key, key[63] = FIPS bit 1, parity bits ignored
//   decrypt     in   1    sampled with start; 1 = pack keys in reverse order
//   ready       out  1    high in IDLE
//   busy        out  1    high while rounds are being computed
//   keys_valid  out  1    one-cycle pulse after round_keys is updated
//   round_keys  out  768  packed round keys (K1 at [767:720] when decrypt=0)
// -----------------------------------------------------------------------------
module des_key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [63:0]  key,
    input  logic         decrypt,
    output logic         ready,
    output logic         busy,
    output logic         keys_valid,
    output logic [767:0] round_keys
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Permuted choice 1: entry i names the FIPS key bit that lands in
    // output bit i+1 (output bit 1 is the MSB of {C,D}).
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // Permuted choice 2: selects 48 of the 56 {C,D} bits for each round key.
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // FIPS bit n of a W-bit word sits at vector index W-n.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] v;
        v = '0;
        for (int i = 0; i < 56; i++) begin
            v[55-i] = k[64-PC1_TAB[i]];
        end
        return v;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] v;
        v = '0;
        for (int i = 0; i < 48; i++) begin
            v[47-i] = cd[56-PC2_TAB[i]];
        end
        return v;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] v, input logic two);
        return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    state_t         r_state;
    state_t         w_state_next;
    logic [27:0]    r_c;
    logic [27:0]    r_d;
    logic [4:0]     r_cnt;
    logic           r_decrypt;
    logic [767:0]   r_work;
    logic [767:0]   r_round_keys;
    logic           r_keys_valid;

    logic           w_accept;
    logic           w_last;
    logic           w_rot_two;
    logic [27:0]    w_c_rot;
    logic [27:0]    w_d_rot;
    logic [47:0]    w_k;
    logic [767:0]   w_work_next;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_last    = (r_cnt == 5'd16);
    // Rounds 1, 2, 9 and 16 rotate by one; every other round rotates by two.
    assign w_rot_two = !((r_cnt == 5'd1) || (r_cnt == 5'd2) ||
                         (r_cnt == 5'd9) || (r_cnt == 5'd16));
    assign w_c_rot   = rotl28(r_c, w_rot_two);
    assign w_d_rot   = rotl28(r_d, w_rot_two);
    assign w_k       = pc2({w_c_rot, w_d_rot});
    // Encrypt order shifts in at the LSB end so K1 ends up on top;
    // decrypt order shifts in at the MSB end so K16 ends up on top.
    assign w_work_next = r_decrypt ? {w_k, r_work[767:48]}
                                   : {r_work[719:0], w_k};

    // NOTE: reset is sampled on the clock edge only (synchronous), and all
    // state uses non-blocking assignments so every register sees the
    // pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_c          <= '0;
            r_d          <= '0;
            r_cnt        <= '0;
            r_decrypt    <= 1'b0;
            r_work       <= '0;
            r_round_keys <= '0;
            r_keys_valid <= 1'b0;
        end else begin
            r_keys_valid <= 1'b0;
            if (w_accept) begin
                {r_c, r_d} <= pc1(key);
                r_cnt      <= 5'd1;
                r_decrypt  <= decrypt;
            end else if (r_state == S_RUN) begin
                r_c    <= w_c_rot;
                r_d    <= w_d_rot;
                r_work <= w_work_next;
                r_cnt  <= r_cnt + 5'd1;
                if (w_last) begin
                    // Publish the set including K16, which is only being
                    // shifted into r_work on this same edge.
                    r_round_keys <= w_work_next;
                    r_keys_valid <= 1'b1;
                    r_cnt        <= '0;
                end
            end
        end
    end

    assign keys_valid = r_keys_valid;
    assign round_keys = r_round_keys;

endmodule

// File: tb/tb_des_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_des_key_schedule
//
// Directed bench for des_key_schedule. Expected key sets are queued when a
// start is issued and checked by a monitor when keys_valid pulses, together
// with the arrival cycle.
// -----------------------------------------------------------------------------
module tb_des_key_schedule;

    localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] WEAK_0   = 64'h0101010101010101;
    localparam logic [63:0] WEAK_1   = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [47:0] K1       = 48'h1B02EFFC7072;
    localparam logic [47:0] K2       = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16      = 48'hCB3D8B0E17F5;

    typedef struct {
        string          tag;
        int             due;
        bit             full_chk;
        bit             dec;
        logic [767:0]   full_v;
        logic [47:0]    top;
        logic [47:0]    second;
        logic [47:0]    bottom;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [63:0]  key;
    logic         decrypt;
    logic         ready;
    logic         busy;
    logic         keys_valid;
    logic [767:0] round_keys;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t sb[$];
    int   valid_cyc[$];
    logic prev_valid = 1'b0;

    des_key_schedule dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key        (key),
        .decrypt    (decrypt),
        .ready      (ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .round_keys (round_keys)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_part(input string tag, input bit dec,
                                     input logic [47:0] top, input logic [47:0] second,
                                     input logic [47:0] bottom);
        exp_t e;
        e.tag      = tag;
        e.due      = 0;
        e.full_chk = 1'b0;
        e.dec      = dec;
        e.full_v   = '0;
        e.top      = top;
        e.second   = second;
        e.bottom   = bottom;
        return e;
    endfunction

    function automatic exp_t mk_full(input string tag, input logic [767:0] v);
        exp_t e;
        e          = mk_part(tag, 1'b0, '0, '0, '0);
        e.full_chk = 1'b1;
        e.full_v   = v;
        return e;
    endfunction

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (prev_valid === 1'b1) begin
            check("keys_valid_one_cycle", 768'(keys_valid), 768'(1'b0));
        end
        prev_valid = keys_valid;
        if (keys_valid === 1'b1) begin
            valid_cyc.push_back(cyc);
            check("keys_valid_expected", 768'(sb.size() != 0), 768'(1'b1));
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_latency"}, 768'(cyc), 768'(e.due));
                if (e.full_chk) begin
                    check({e.tag, "_all"}, round_keys, e.full_v);
                end else begin
                    check({e.tag, "_top"}, 768'(round_keys[767:720]), 768'(e.top));
                    if (e.dec) begin
                        check({e.tag, "_95_48"}, 768'(round_keys[95:48]), 768'(e.second));
                    end else begin
                        check({e.tag, "_719_672"}, 768'(round_keys[719:672]), 768'(e.second));
                    end
                    check({e.tag, "_bottom"}, 768'(round_keys[47:0]), 768'(e.bottom));
                end
            end
        end
    end

    // Drive start for one cycle; exp_acc says whether the bench expects it taken.
    task automatic do_start(input logic [63:0] k, input logic dec, input logic exp_acc,
                            input exp_t e);
        exp_t ee;
        ee = e;
        @(negedge clk);
        check({e.tag, "_ready_at_start"}, 768'(ready), 768'(exp_acc));
        start   = 1'b1;
        key     = k;
        decrypt = dec;
        if (exp_acc) begin
            ee.due = cyc + 17;
            sb.push_back(ee);
        end
        @(negedge clk);
        start   = 1'b0;
        key     = {$urandom, $urandom};
        decrypt = ~dec;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 768'(sb.size()), 768'(0));
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        key     = '0;
        decrypt = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready",      768'(ready),      768'(1'b1));
        check("rst_busy",       768'(busy),       768'(1'b0));
        check("rst_keys_valid", 768'(keys_valid), 768'(1'b0));
        check("rst_round_keys", round_keys,       '0);
        rst_n = 1'b1;

        // FIPS vector, both packing orders.
        do_start(FIPS_KEY, 1'b0, 1'b1, mk_part("fips_enc", 1'b0, K1, K2, K16));
        check("run_busy",  768'(busy),  768'(1'b1));
        check("run_ready", 768'(ready), 768'(1'b0));
        wait_idle("fips_enc");
        do_start(FIPS_KEY, 1'b1, 1'b1, mk_part("fips_dec", 1'b1, K16, K2, K1));
        wait_idle("fips_dec");

        // Weak keys: only parity bits set, or only parity bits clear.
        do_start(WEAK_0, 1'b0, 1'b1, mk_full("weak_zero", '0));
        wait_idle("weak_zero");
        do_start(WEAK_1, 1'b1, 1'b1, mk_full("weak_ones", '1));
        wait_idle("weak_ones");

        // Start during RUN is ignored; round_keys holds the all-ones set meanwhile.
        do_start(FIPS_KEY, 1'b0, 1'b1, mk_part("ignore_start", 1'b0, K1, K2, K16));
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            check($sformatf("hold_during_run_%0d", i), round_keys, '1);
            if (i == 5) begin
                check("ready_in_run", 768'(ready), 768'(1'b0));
                start   = 1'b1;
                key     = WEAK_0;
                decrypt = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        wait_idle("ignore_start");
        repeat (20) @(negedge clk);

        // Reset asserted at round 8 discards the partial schedule.
        do_start(WEAK_1, 1'b1, 1'b1, mk_full("aborted", '1));
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        sb.delete();
        check("midrst_round_keys", round_keys,       '0);
        check("midrst_busy",       768'(busy),       768'(1'b0));
        check("midrst_ready",      768'(ready),      768'(1'b1));
        check("midrst_keys_valid", 768'(keys_valid), 768'(1'b0));
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        do_start(FIPS_KEY, 1'b0, 1'b1, mk_part("after_rst", 1'b0, K1, K2, K16));
        wait_idle("after_rst");

        // Back-to-back: second start sampled in the keys_valid cycle.
        valid_cyc.delete();
        do_start(WEAK_1, 1'b0, 1'b1, mk_full("b2b_first", '1));
        repeat (15) @(negedge clk);
        do_start(FIPS_KEY, 1'b1, 1'b1, mk_part("b2b_second", 1'b1, K16, K2, K1));
        wait_idle("b2b_second");
        check("b2b_valid_count", 768'(valid_cyc.size()), 768'(2));
        if (valid_cyc.size() == 2) begin
            check("b2b_spacing", 768'(valid_cyc[1] - valid_cyc[0]), 768'(17));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Iterative DES key schedule that expands one 64-bit key into the 16 packed 48-bit round keys.
- Produces one round key per cycle.
- Sits directly upstream of des_encryption_pipelined and drives its 768-bit round_keys bus.
- The output bus is double-buffered, so the downstream pipeline keeps using the previous key set while a new one is computed.

Parameters:
- none: all widths are fixed by FIPS 46-3.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; synchronous, active-low
- start  input  1  request a new schedule; sampled only when ready=1
- key  input  64  DES key; key[63] = FIPS bit 1; parity bits (FIPS 8,16,...,64) ignored
- decrypt  input  1  sampled with start; 1 = pack keys in reverse order
- ready  output  1  high in IDLE; start is accepted only then
- busy  output  1  high while rounds are being computed
- keys_valid  output  1  one-cycle pulse when round_keys has just been updated
- round_keys  output  768  packed round keys, registered

Behaviour:
- Reset (rst_n=0 at a clock edge), including mid-operation:
  - state=IDLE, ready=1, busy=0, keys_valid=0, round_keys=0.
  - Working registers and round counter are cleared.
  - A partial schedule is discarded.
- States:
  - IDLE: ready=1, busy=0. On start=1 at edge E0: latch decrypt, load C/D = PC-1(key) as C0 (28b, upper) and D0 (28b, lower), counter=1, go to RUN.
  - RUN: busy=1, ready=0. At each edge Ei, i=1..16:
    - Rotate C and D left by S(i).
    - Compute Ki = PC-2({C,D}).
    - Shift Ki into the 768-bit working register.
    - Increment counter.
  - Transition at E16: copy the working register to round_keys, pulse keys_valid=1 for exactly one cycle, return to IDLE.
- Shift table S(1..16) = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. The total rotation is 28, so C16=C0 and D16=D0; no wrap correction is needed.
- Packing, decrypt=0 (shift in at the LSB end):
  - K1 in round_keys[767:720], K2 in [719:672], ..., K16 in [47:0].
  - Within each Ki, FIPS bit 1 is the MSB.
- Packing, decrypt=1 (shift in at the MSB end):
  - K16 in [767:720], ..., K1 in [47:0].
  - This lets the same downstream core decrypt.
- Latency: start sampled at E0 → keys_valid high in the cycle after E16, i.e. 16 cycles from acceptance to valid.
  - Back-to-back operation: ready is high in the cycle keys_valid is high, so the next start can be sampled at E17.
  - Throughput is one schedule per 17 cycles.
- round_keys changes only at completion edges; it is stable otherwise, including throughout RUN.
- start while busy is ignored: no queuing and no restart.
- key and decrypt are don't-care except at the accepting edge.
- Reset asserted in the same cycle as start: reset wins.

Test Plan:
- FIPS vector: key=64'h133457799BBCDFF1, decrypt=0, start for one cycle →
  - keys_valid exactly 16 cycles later;
  - round_keys[767:720]=48'h1B02EFFC7072, [719:672]=48'h79AED9DBC9E5, [47:0]=48'hCB3D8B0E17F5.
- Same key, decrypt=1 →
  - round_keys[767:720]=48'hCB3D8B0E17F5;
  - [47:0]=48'h1B02EFFC7072;
  - [95:48]=48'h79AED9DBC9E5.
- Parity and weak keys:
  - key=64'h0101010101010101 → round_keys all zero, keys_valid pulses.
  - key=64'hFEFEFEFEFEFEFEFE → round_keys all ones.
- Handshake:
  - Pulse start again at cycle 5 of RUN with a different key → ignored; result matches the first key, keys_valid pulses once.
  - round_keys holds its previous value through all of RUN.
- Reset mid-operation: rst_n=0 at round 8 →
  - next cycle round_keys=0, busy=0, ready=1, no keys_valid pulse;
  - a new start then completes normally in 16 cycles.
- Back-to-back:
  - start sampled in the keys_valid cycle → accepted.
  - Second keys_valid comes 17 cycles after the first.
  - End-to-end with des_encryption_pipelined: plaintext 64'h0123456789ABCDEF encrypts to 64'h85E813540F0AB405.
